// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment / BCD conversion path.
package seg7_pkg;
  localparam int N_DIGITS = 4;
  localparam int IDX_W    = 2;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic any_invalid(input logic [N_DIGITS-1:0][3:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++)
      if (d[i] > BCD_MAX) bad = 1'b1;
    return bad;
  endfunction
endpackage

// File: rtl/digit_mac.sv
// Combinational Horner step: res = acc*10 + digit, truncated to NUM_W.
module digit_mac #(
  parameter int NUM_W = 16
) (
  input  logic [NUM_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [NUM_W-1:0] res
);
  assign res = (acc << 3) + (acc << 1) + NUM_W'(digit);
endmodule

// File: rtl/digits_to_dec.sv
// Iterative four-digit BCD to binary converter, one digit per clock,
// with start/busy/done handshake and invalid-digit flagging.
module digits_to_dec
  import seg7_pkg::*;
#(
  parameter int               NUM_W     = 16,
  parameter logic [NUM_W-1:0] ERR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       i_Digit1,
  input  logic [3:0]       i_Digit2,
  input  logic [3:0]       i_Digit3,
  input  logic [3:0]       i_Digit4,
  output logic [NUM_W-1:0] o_num,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  state_t                    state;
  logic [N_DIGITS-1:0][3:0]  dig;
  logic [N_DIGITS-1:0][3:0]  dig_in;
  logic [NUM_W-1:0]          acc;
  logic [NUM_W-1:0]          mac;
  logic [IDX_W-1:0]          idx;
  logic                      err;

  // Element 0 is the thousands digit so idx walks most significant first.
  assign dig_in = {i_Digit1, i_Digit2, i_Digit3, i_Digit4};

  digit_mac #(.NUM_W(NUM_W)) u_mac (
    .acc  (acc),
    .digit(dig[idx]),
    .res  (mac)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      dig    <= '0;
      acc    <= '0;
      idx    <= '0;
      err    <= 1'b0;
      o_num  <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dig    <= dig_in;
            acc    <= '0;
            idx    <= '0;
            o_busy <= 1'b1;
            err    <= any_invalid(dig_in);
            state  <= any_invalid(dig_in) ? ST_FINISH : ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= mac;
          idx <= idx + 1'b1;
          if (idx == IDX_W'(N_DIGITS - 1)) state <= ST_FINISH;
        end
        ST_FINISH: begin
          o_num  <= err ? ERR_VALUE : acc;
          o_err  <= err;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_digits_to_dec.sv
// Directed bench for digits_to_dec: latency, values, errors, ignored starts,
// back-to-back conversions and asynchronous reset.
module tb_digits_to_dec;
  localparam int NUM_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       d1, d2, d3, d4;
  logic [NUM_W-1:0] o_num;
  logic             o_busy, o_done, o_err;

  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  digits_to_dec #(.NUM_W(NUM_W), .ERR_VALUE('0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .i_Digit1(d1), .i_Digit2(d2), .i_Digit3(d3), .i_Digit4(d4),
    .o_num(o_num), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present digits with start high across one edge (edge k), then drop start
  // and scramble the inputs to prove they were latched.
  task automatic launch(input logic [3:0] a4, a3, a2, a1);
    d4 = a4; d3 = a3; d2 = a2; d1 = a1;
    start = 1'b1;
    tick();
    start = 1'b0;
    d4 = 4'd7; d3 = 4'd7; d2 = 4'd7; d1 = 4'd7;
  endtask

  // Checks the full valid-digit timeline from edge k through k+6.
  task automatic run_valid(input string name, input logic [3:0] a4, a3, a2, a1,
                           input logic [NUM_W-1:0] exp);
    launch(a4, a3, a2, a1);
    for (int i = 0; i < 5; i++) begin
      vec++;
      if (o_busy !== 1'b1 || o_done !== 1'b0) begin
        miss++;
        $display("FAIL %s busy/done at k+%0d: got busy=%b done=%b, want busy=1 done=0",
                 name, i, o_busy, o_done);
      end
      tick();
    end
    vec++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_num !== exp || o_err !== 1'b0) begin
      miss++;
      $display("FAIL %s finish: got done=%b busy=%b num=%0d err=%b, want done=1 busy=0 num=%0d err=0",
               name, o_done, o_busy, o_num, o_err, exp);
    end
    tick();
    vec++;
    if (o_done !== 1'b0 || o_num !== exp) begin
      miss++;
      $display("FAIL %s done_clear: got done=%b num=%0d, want done=0 num=%0d",
               name, o_done, o_num, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    tick(); tick();
    vec++;
    if (o_num !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin
      miss++;
      $display("FAIL reset_state: got num=%0d busy=%b done=%b err=%b, want all 0",
               o_num, o_busy, o_done, o_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_valid("basic_5432", 4'd5, 4'd4, 4'd3, 4'd2, 16'd5432);
  endtask

  task automatic test_extremes();
    run_valid("max_9999", 4'd9, 4'd9, 4'd9, 4'd9, 16'd9999);
    launch(4'd0, 4'd0, 4'd0, 4'd0);
    tick(); tick();
    vec++;
    if (o_num !== 16'd9999) begin
      miss++;
      $display("FAIL hold_9999: got num=%0d during CALC, want 9999", o_num);
    end
    tick(); tick(); tick();
    vec++;
    if (o_done !== 1'b1 || o_num !== 16'd0) begin
      miss++;
      $display("FAIL zero_0000: got done=%b num=%0d, want done=1 num=0", o_done, o_num);
    end
    tick();
  endtask

  task automatic test_invalid();
    launch(4'd1, 4'd1, 4'hA, 4'd1);
    vec++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      miss++;
      $display("FAIL invalid_k: got busy=%b done=%b, want busy=1 done=0", o_busy, o_done);
    end
    tick();
    vec++;
    if (o_done !== 1'b1 || o_err !== 1'b1 || o_num !== 16'd0 || o_busy !== 1'b0) begin
      miss++;
      $display("FAIL invalid_finish: got done=%b err=%b num=%0d busy=%b, want done=1 err=1 num=0 busy=0",
               o_done, o_err, o_num, o_busy);
    end
    tick();
    vec++;
    if (o_err !== 1'b1 || o_done !== 1'b0) begin
      miss++;
      $display("FAIL invalid_hold: got err=%b done=%b, want err=1 done=0", o_err, o_done);
    end
    run_valid("after_err_0012", 4'd0, 4'd0, 4'd1, 4'd2, 16'd12);
  endtask

  task automatic test_start_ignored();
    int dones;
    dones = 0;
    launch(4'd3, 4'd1, 4'd4, 4'd1);
    tick();
    d4 = 4'd9; d3 = 4'd8; d2 = 4'd7; d1 = 4'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (o_done === 1'b1) begin
        dones++;
        vec++;
        if (o_num !== 16'd3141) begin
          miss++;
          $display("FAIL ignored_value: got num=%0d, want 3141", o_num);
        end
      end
      tick();
    end
    vec++;
    if (dones != 1) begin
      miss++;
      $display("FAIL ignored_done_count: got %0d pulses, want 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    int waited;
    d4 = 4'd1; d3 = 4'd2; d2 = 4'd3; d1 = 4'd4;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vec++;
      if (o_done !== ((i % 6) == 5)) begin
        miss++;
        $display("FAIL b2b_done at k+%0d: got %b, want %b", i, o_done, (i % 6) == 5);
      end
      if ((i % 6) == 5) begin
        vec++;
        if (o_num !== 16'd1234) begin
          miss++;
          $display("FAIL b2b_value at k+%0d: got %0d, want 1234", i, o_num);
        end
      end
    end
    start = 1'b0;
    waited = 0;
    while (o_busy === 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    vec++;
    if (o_busy !== 1'b0) begin
      miss++;
      $display("FAIL b2b_drain: busy still %b after %0d cycles, want 0", o_busy, waited);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    launch(4'd5, 4'd5, 4'd5, 4'd5);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    vec++;
    if (o_num !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin
      miss++;
      $display("FAIL async_reset: got num=%0d busy=%b done=%b err=%b, want all 0",
               o_num, o_busy, o_done, o_err);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (o_done === 1'b1) dones++;
    end
    vec++;
    if (dones != 0 || o_num !== '0) begin
      miss++;
      $display("FAIL reset_discard: got %0d done pulses num=%0d, want 0 and 0", dones, o_num);
    end
    run_valid("after_reset_2024", 4'd2, 4'd0, 4'd2, 4'd4, 16'd2024);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_invalid();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
